// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU-control codes and multiply-sequencer constants.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALU_CTRL_NOP = 3'b000;
  localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIter = 2'b01,
    StDone = 2'b10
  } seq_state_e;

  localparam int unsigned MulIters  = 32;
  localparam logic [4:0]  LastCount = 5'(MulIters - 1);

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared EX-stage ALU for its 32 add steps.
// Define MUL_HI_EN to get the upper 32 product bits on hi (otherwise hi is tied to 0).
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ex_alu_ctrl,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        start,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  seq_state_e  r_state, w_state_next;
  logic [31:0] r_mcand, r_hi, r_lo;
  logic [4:0]  r_count;
  logic [31:0] w_sum;
  logic        w_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StIter;
      StIter:  if (r_count == LastCount) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    alu_ctrl = ex_alu_ctrl;
    alu_a    = ex_a;
    alu_b    = ex_b;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      StIdle: ;
      StIter: begin
        alu_ctrl = r_lo[0] ? ALU_CTRL_ADD : ALU_CTRL_NOP;
        alu_a    = r_hi;
        alu_b    = r_mcand;
        busy     = 1'b1;
      end
      StDone: begin
        alu_ctrl = ALU_CTRL_NOP;
        alu_a    = r_hi;
        alu_b    = r_mcand;
        busy     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum = r_lo[0] ? alu_result : r_hi;

  // An unsigned wrap of hi + mcand shows up as a result smaller than hi.
`ifdef MUL_HI_EN
  assign w_carry = r_lo[0] & (alu_result < r_hi);
  assign hi      = r_hi;
`else
  assign w_carry = 1'b0;
  assign hi      = '0;
`endif

  assign lo = r_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (r_state == StIdle && start) begin
      r_mcand <= mul_a;
      r_hi    <= '0;
      r_lo    <= mul_b;
      r_count <= '0;
    end else if (r_state == StIter) begin
      {r_hi, r_lo} <= {w_carry, w_sum, r_lo[31:1]};
      r_count      <= r_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

`ifdef MUL_HI_EN
  localparam bit HiEn = 1'b1;
`else
  localparam bit HiEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ex_alu_ctrl;
  logic [31:0] ex_a, ex_b;
  logic        start;
  logic [31:0] mul_a, mul_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy, done;
  logic [31:0] lo, hi;

  int n_checks = 0;
  int n_errors = 0;

  logic       busy_tr [0:40];
  logic [2:0] ctrl_tr [0:40];

  always #5 clk = ~clk;

  alu_mul_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_alu_ctrl(ex_alu_ctrl),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .start      (start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .lo         (lo),
    .hi         (hi)
  );

  // Shared ALU model
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_CTRL_ADD: alu_result = alu_a + alu_b;
      ALU_CTRL_SUB: alu_result = alu_a - alu_b;
      default:      alu_result = '0;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a multiply and watches a fixed 40-cycle window after the accepting edge.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int extra_at,
                         input int rst_at, output int first_done, output int n_done);
    first_done = -1;
    n_done     = 0;
    @(negedge clk);
    start = 1'b1;
    mul_a = a;
    mul_b = b;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      busy_tr[n] = busy;
      ctrl_tr[n] = alu_ctrl;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (!rst_n) rst_n = 1'b1;
      if (extra_at > 0 && n == extra_at + 1) start = 1'b0;
      if (extra_at > 0 && n == extra_at) begin
        start = 1'b1;
        mul_a = 32'h0000_DEAD;
        mul_b = 32'h0000_BEEF;
      end
      if (n == rst_at) rst_n = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd, nd;
    logic [31:0] eh;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        32'd0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{32'h1234_5678, 32'h0000_0002, 32'h2468_ACF0, 32'h0000_0000};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0010, 32'hEADB_EEF0, 32'h0000_000D};
    vecs[5] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0006};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};

    rst_n       = 1'b0;
    start       = 1'b0;
    mul_a       = '0;
    mul_b       = '0;
    ex_alu_ctrl = ALU_CTRL_SUB;
    ex_a        = 32'd7;
    ex_b        = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("pass_ctrl", 64'(alu_ctrl), 64'(ALU_CTRL_SUB));
    check("pass_a", 64'(alu_a), 64'd7);
    check("pass_b", 64'(alu_b), 64'd2);

    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, 0, 0, fd, nd);
      eh = HiEn ? vecs[i].exp_hi : 32'd0;
      check($sformatf("v%0d_latency", i), 64'(fd), 64'd33);
      check($sformatf("v%0d_ndone", i), 64'(nd), 64'd1);
      check($sformatf("v%0d_busy1", i), 64'(busy_tr[1]), 64'd1);
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(eh));
      if (i == 2) begin
        check("b2_ctrl_iter1", 64'(ctrl_tr[1]), 64'(ALU_CTRL_NOP));
        check("b2_ctrl_iter2", 64'(ctrl_tr[2]), 64'(ALU_CTRL_ADD));
      end
    end

    // Start 5 cycles into ITER must be ignored.
    run_mul(32'h0000_1234, 32'h0000_0010, 5, 0, fd, nd);
    check("mid_latency", 64'(fd), 64'd33);
    check("mid_ndone", 64'(nd), 64'd1);
    check("mid_lo", 64'(lo), 64'h0001_2340);
    check("mid_hi", 64'(hi), 64'd0);

    // Start in the DONE cycle must be ignored; product holds afterwards.
    run_mul(32'd6, 32'd7, 33, 0, fd, nd);
    check("donestart_ndone", 64'(nd), 64'd1);
    check("donestart_busy", 64'(busy_tr[34]), 64'd0);
    check("donestart_lo", 64'(lo), 64'd42);
    check("donestart_idle_pass", 64'(alu_ctrl), 64'(ALU_CTRL_SUB));

    // Reset asserted at ITER cycle 10.
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10, fd, nd);
    check("rstmid_busy10", 64'(busy_tr[10]), 64'd1);
    check("rstmid_busy11", 64'(busy_tr[11]), 64'd0);
    check("rstmid_ndone", 64'(nd), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);

    // Recovery after the mid-run reset.
    run_mul(32'd9, 32'd11, 0, 0, fd, nd);
    check("recover_latency", 64'(fd), 64'd33);
    check("recover_lo", 64'(lo), 64'd99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: ex_alu_ctrl  in  3  EX-stage ALU control code; ex_a, ex_b  in  32  EX-stage operands.
REQ-004 SHALL have ports: start  in  1  multiply request; mul_a, mul_b  in  32  unsigned multiplicand and multiplier.
REQ-005 SHALL have ports: alu_ctrl  out  3, alu_a, alu_b  out  32  to the shared ALU; alu_result  in  32  from the shared ALU.
REQ-006 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; lo, hi  out  32  product halves.

Function
REQ-007 SHALL implement FSM states IDLE, ITER and DONE.
REQ-008 IDLE SHALL pass through: alu_ctrl=ex_alu_ctrl, alu_a=ex_a, alu_b=ex_b, combinationally.
REQ-009 start=1 in IDLE SHALL load mcand=mul_a, hi=0, lo=mul_b, count=0 and enter ITER at the next edge.
REQ-010 ITER with lo[0]=1 SHALL drive alu_ctrl=ALU_CTRL_ADD, alu_a=hi, alu_b=mcand.
REQ-011 ITER with lo[0]=0 SHALL drive alu_ctrl=ALU_CTRL_NOP; alu_a and alu_b are don't-care.
REQ-012 Each ITER edge SHALL compute s = lo[0] ? alu_result : hi, c = lo[0] & (alu_result < hi, unsigned), then {hi,lo} <= {c,s,lo}>>1, count+1.
REQ-013 After the 32nd ITER edge (count=31) the FSM SHALL enter DONE; done=1 for exactly that one cycle, then IDLE.
REQ-014 Start-to-done latency SHALL be fixed at 33 cycles regardless of operand values; no early exit.
REQ-015 busy SHALL be 1 in ITER and DONE, 0 in IDLE; the pipeline uses busy as a stall.
REQ-016 start while busy=1 SHALL be ignored and have no later effect.
REQ-017 lo and hi SHALL hold the final product from DONE until the next accepted start.
REQ-018 start asserted in the DONE cycle SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-019 rst_n=0 at any edge, including mid-ITER, SHALL force IDLE, count=0, mcand=0, hi=0, lo=0.
REQ-020 After reset: busy=0, done=0, lo=0, hi=0, and ALU outputs follow pass-through.
REQ-021 rst_n SHALL take priority over start at the same edge.

Configuration
REQ-022 Macro MUL_HI_EN SHALL select full 64-bit product support.
REQ-023 With MUL_HI_EN defined: carry c is computed per REQ-012 and hi outputs the upper 32 product bits.
REQ-024 With MUL_HI_EN undefined:
- carry logic is omitted (c=0);
- hi output is tied to 0;
- lo still equals the low 32 product bits;
- timing is identical.

Structure
REQ-025 ALU_CTRL_ADD and ALU_CTRL_NOP SHALL come from the shared ALU-control constants header; no local redefinition.
REQ-026 FSM state encodings and iteration count (32) SHALL be constants in a shared sequencer header.
REQ-027 There SHALL be no sub-modules; the ALU itself stays outside this block and is shared via the mux.

Verification
REQ-028 Reset, then ex_alu_ctrl=ALU_CTRL_SUB, ex_a=7, ex_b=2 -> alu_ctrl=SUB, alu_a=7, alu_b=2, busy=0.
REQ-029 start with mul_a=3, mul_b=5 -> busy next cycle; done exactly 33 cycles after start; lo=15, hi=0.
REQ-030 mul_a=mul_b=0xFFFFFFFF -> with MUL_HI_EN: hi=0xFFFFFFFE, lo=0x00000001; without: hi=0, lo=0x00000001.
REQ-031 mul_b=0x00000002 -> alu_ctrl=NOP in the first ITER cycle, ADD in the second; lo=2*mul_a.
REQ-032 Second start pulse asserted 5 cycles into ITER -> ignored; only one done pulse and the original product.
REQ-033 rst_n=0 at ITER cycle 10 -> next cycle IDLE, busy=0, done never asserts, lo=hi=0.
